// File: rtl/mr_ifetch.sv
// mr_ifetch: instruction fetch stage feeding decode.
// Issues sequential word reads on a valid/ready memory bus, pairs returned words
// with their PCs in a small FIFO, and on a redirect flushes queued words while
// discarding responses that were already in flight for the old path.
`timescale 1ns/1ps

module mr_ifetch #(
  parameter int              XLEN     = 32,
  parameter int              IMAXLEN  = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  logic               clk,
  input  logic               rst,
  output logic               mem_req_valid,
  input  logic               mem_req_ready,
  output logic [XLEN-1:0]    mem_req_addr,
  input  logic               mem_rsp_valid,
  input  logic [IMAXLEN-1:0] mem_rsp_data,
  input  logic               redir_valid,
  input  logic [XLEN-1:0]    redir_pc,
  output logic [IMAXLEN-1:0] inst,
  output logic [XLEN-1:0]    inst_pc,
  output logic               inst_valid,
  input  logic               inst_ready
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0]   CREDITS  = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Fetch state
  logic [XLEN-1:0]    r_pc;
  logic [CW-1:0]      r_outstanding;
  logic [CW-1:0]      r_dropCnt;
  logic [CW-1:0]      r_fifoCount;
  logic [PW-1:0]      r_fifoWr;
  logic [PW-1:0]      r_fifoRd;
  logic [PW-1:0]      r_ifqWr;
  logic [PW-1:0]      r_ifqRd;
  logic [IMAXLEN-1:0] r_fifoInst [DEPTH];
  logic [XLEN-1:0]    r_fifoPc   [DEPTH];
  logic [XLEN-1:0]    r_ifqPc    [DEPTH];

  logic [CW:0]        w_inUse;
  logic               w_reqFire;
  logic               w_rspTake;
  logic               w_rspDrop;
  logic               w_rspPush;
  logic               w_pop;
  logic [XLEN-1:0]    w_redirPc;

  // Words either in flight or buffered may never exceed the FIFO depth, so every
  // returning word is guaranteed a slot.
  assign w_inUse   = {1'b0, r_outstanding} + {1'b0, r_fifoCount};
  assign w_redirPc = redir_pc & {{(XLEN-2){1'b1}}, 2'b00};

  assign mem_req_valid = !rst && !redir_valid && (w_inUse < CREDITS) && (r_dropCnt == '0);
  assign mem_req_addr  = r_pc;
  assign w_reqFire     = mem_req_valid && mem_req_ready;

  // A response either retires a stale request (drop) or belongs to the current path.
  assign w_rspDrop = mem_rsp_valid && (r_dropCnt != '0);
  assign w_rspTake = mem_rsp_valid && (r_dropCnt == '0);
  assign w_rspPush = w_rspTake && !redir_valid;

  assign inst_valid = (r_fifoCount != '0) && !redir_valid;
  assign inst       = r_fifoInst[r_fifoRd];
  assign inst_pc    = r_fifoPc[r_fifoRd];
  assign w_pop      = inst_valid && inst_ready;

  // PC, credit counters and queue pointers; a redirect overrides all normal updates
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_outstanding <= '0;
      r_dropCnt     <= '0;
      r_fifoCount   <= '0;
      r_fifoWr      <= '0;
      r_fifoRd      <= '0;
      r_ifqWr       <= '0;
      r_ifqRd       <= '0;
    end else if (redir_valid) begin
      r_pc          <= w_redirPc;
      r_dropCnt     <= r_dropCnt + r_outstanding - CW'(mem_rsp_valid);
      r_outstanding <= '0;
      r_fifoCount   <= '0;
      r_fifoWr      <= '0;
      r_fifoRd      <= '0;
      r_ifqWr       <= '0;
      r_ifqRd       <= '0;
    end else begin
      if (w_reqFire) begin
        r_pc    <= r_pc + XLEN'(4);
        r_ifqWr <= r_ifqWr + PW'(1);
      end
      if (w_rspTake) begin
        r_ifqRd <= r_ifqRd + PW'(1);
      end
      if (w_rspDrop) begin
        r_dropCnt <= r_dropCnt - CW'(1);
      end
      if (w_rspPush) begin
        r_fifoWr <= r_fifoWr + PW'(1);
      end
      if (w_pop) begin
        r_fifoRd <= r_fifoRd + PW'(1);
      end
      r_outstanding <= r_outstanding + CW'(w_reqFire) - CW'(w_rspTake);
      r_fifoCount   <= r_fifoCount + CW'(w_rspPush) - CW'(w_pop);
    end
  end

  // Storage: in-flight PCs captured on accept, instruction/PC pairs captured on response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_fifoInst[i] <= '0;
        r_fifoPc[i]   <= '0;
        r_ifqPc[i]    <= '0;
      end
    end else begin
      if (w_reqFire) begin
        r_ifqPc[r_ifqWr] <= r_pc;
      end
      if (w_rspPush) begin
        r_fifoInst[r_fifoWr] <= mem_rsp_data;
        r_fifoPc[r_fifoWr]   <= r_ifqPc[r_ifqRd];
      end
    end
  end

  // Sanity: no FIFO overflow and no response without a matching request
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(w_rspPush && (r_fifoCount == FULL_CNT) && !w_pop));
      assert (!(w_rspTake && (r_outstanding == '0)));
    end
  end

endmodule

// File: tb/tb_mr_ifetch.sv
// tb_mr_ifetch: directed cycle-by-cycle bench for the fetch stage with a small
// in-order memory model whose response latency can be stretched by holding it.
`timescale 1ns/1ps

module tb_mr_ifetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data  = '0;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  int          cyc     = 0;
  logic        memHold = 1'b0;
  logic [31:0] addrQ[$];
  int          dueQ[$];

  mr_ifetch #(
    .XLEN(32), .IMAXLEN(32), .RESET_PC(32'h0), .DEPTH(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data),
    .redir_valid(redir_valid),
    .redir_pc(redir_pc),
    .inst(inst),
    .inst_pc(inst_pc),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memData(input logic [31:0] a);
    return 32'hA500_0000 | a;
  endfunction

  // Memory model: record accepted requests mid-cycle
  always @(negedge clk) begin
    if (!rst && mem_req_valid && mem_req_ready) begin
      addrQ.push_back(mem_req_addr);
      dueQ.push_back(cyc + 1);
    end
  end

  // Memory model: return responses in order, one cycle after accept unless held
  always @(posedge clk) begin
    cyc <= cyc + 1;
    #2;
    if (rst) begin
      addrQ.delete();
      dueQ.delete();
      mem_rsp_valid <= 1'b0;
    end else if (!memHold && (addrQ.size() > 0) && (dueQ[0] <= cyc)) begin
      mem_rsp_valid <= 1'b1;
      mem_rsp_data  <= memData(addrQ.pop_front());
      void'(dueQ.pop_front());
    end else begin
      mem_rsp_valid <= 1'b0;
    end
  end

  task automatic applyStimulus(input logic reqReady, input logic instReady,
                               input logic redir, input logic [31:0] redirPc);
    @(posedge clk);
    #1;
    mem_req_ready = reqReady;
    inst_ready    = instReady;
    redir_valid   = redir;
    redir_pc      = redirPc;
    #3;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkFlag(input string tag, input logic obs, input logic exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Watchdog so the run always ends
  initial begin
    #20000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst = 1'b1; mem_req_ready = 1'b1; redir_valid = 1'b0; redir_pc = '0; inst_ready = 1'b1;
    repeat (2) @(posedge clk);
    #4;
    checkFlag  ("rst reqValid",  mem_req_valid, 1'b0);
    checkFlag  ("rst instValid", inst_valid,    1'b0);
    checkOutput("rst reqAddr",   mem_req_addr,  32'h0);
    checkOutput("rst inst",      inst,          32'h0);
    checkOutput("rst instPc",    inst_pc,       32'h0);

    // Sequential fetch, one-cycle memory latency, decode always ready
    @(posedge clk); #1; rst = 1'b0; #3;
    checkFlag  ("c0 reqValid",  mem_req_valid, 1'b1);
    checkOutput("c0 reqAddr",   mem_req_addr,  32'h0);
    checkFlag  ("c0 instValid", inst_valid,    1'b0);
    applyStimulus(1, 1, 0, 0);
    checkOutput("c1 reqAddr",   mem_req_addr,  32'h4);
    checkFlag  ("c1 instValid", inst_valid,    1'b0);
    applyStimulus(1, 1, 0, 0);
    checkFlag  ("c2 instValid", inst_valid,    1'b1);
    checkOutput("c2 instPc",    inst_pc,       32'h0);
    checkOutput("c2 inst",      inst,          32'hA500_0000);
    checkFlag  ("c2 reqValid",  mem_req_valid, 1'b0);
    applyStimulus(1, 1, 0, 0);
    checkOutput("c3 instPc",    inst_pc,       32'h4);
    checkFlag  ("c3 reqValid",  mem_req_valid, 1'b1);
    checkOutput("c3 reqAddr",   mem_req_addr,  32'h8);
    applyStimulus(1, 1, 0, 0);
    checkFlag  ("c4 instValid", inst_valid,    1'b0);
    checkOutput("c4 reqAddr",   mem_req_addr,  32'hC);
    applyStimulus(1, 1, 0, 0);
    checkFlag  ("c5 instValid", inst_valid,    1'b1);
    checkOutput("c5 instPc",    inst_pc,       32'h8);
    applyStimulus(1, 1, 0, 0);
    checkOutput("c6 instPc",    inst_pc,       32'hC);
    checkOutput("c6 reqAddr",   mem_req_addr,  32'h10);

    // Decode stalls for six cycles: FIFO fills to two words and fetch stops
    applyStimulus(1, 0, 0, 0);
    checkFlag  ("c7 instValid", inst_valid,    1'b0);
    checkOutput("c7 reqAddr",   mem_req_addr,  32'h14);
    applyStimulus(1, 0, 0, 0);
    checkFlag  ("c8 instValid", inst_valid,    1'b1);
    checkOutput("c8 instPc",    inst_pc,       32'h10);
    repeat (3) applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    checkFlag  ("c12 reqValid", mem_req_valid, 1'b0);
    checkOutput("c12 instPc",   inst_pc,       32'h10);
    checkOutput("c12 inst",     inst,          32'hA500_0010);
    applyStimulus(1, 1, 0, 0);
    checkOutput("c13 instPc",   inst_pc,       32'h10);
    checkFlag  ("c13 reqValid", mem_req_valid, 1'b0);
    applyStimulus(1, 1, 0, 0);
    checkOutput("c14 instPc",   inst_pc,       32'h14);
    checkOutput("c14 reqAddr",  mem_req_addr,  32'h18);
    applyStimulus(1, 1, 0, 0);
    checkFlag  ("c15 instValid", inst_valid,   1'b0);
    checkOutput("c15 reqAddr",  mem_req_addr,  32'h1C);
    applyStimulus(1, 1, 0, 0);
    checkOutput("c16 instPc",   inst_pc,       32'h18);

    // Hold responses to get two requests in flight, then redirect to 0x103
    memHold = 1'b1;
    applyStimulus(1, 1, 0, 0);
    checkOutput("c17 instPc",   inst_pc,       32'h1C);
    checkOutput("c17 reqAddr",  mem_req_addr,  32'h20);
    applyStimulus(1, 1, 0, 0);
    checkOutput("c18 reqAddr",  mem_req_addr,  32'h24);
    applyStimulus(1, 1, 1, 32'h103);
    checkFlag  ("c19 reqValid", mem_req_valid, 1'b0);
    memHold = 1'b0;
    applyStimulus(1, 1, 0, 0);
    checkFlag  ("c20 reqValid", mem_req_valid, 1'b0);
    checkOutput("c20 reqAddr",  mem_req_addr,  32'h100);
    applyStimulus(1, 1, 0, 0);
    checkFlag  ("c21 reqValid", mem_req_valid, 1'b0);
    checkFlag  ("c21 instValid", inst_valid,   1'b0);
    applyStimulus(1, 1, 0, 0);
    checkFlag  ("c22 reqValid", mem_req_valid, 1'b1);
    checkOutput("c22 reqAddr",  mem_req_addr,  32'h100);
    applyStimulus(1, 1, 0, 0);
    checkOutput("c23 reqAddr",  mem_req_addr,  32'h104);
    applyStimulus(1, 1, 0, 0);
    checkFlag  ("c24 instValid", inst_valid,   1'b1);
    checkOutput("c24 instPc",   inst_pc,       32'h100);
    checkOutput("c24 inst",     inst,          32'hA500_0100);
    applyStimulus(1, 1, 0, 0);
    checkOutput("c25 instPc",   inst_pc,       32'h104);
    applyStimulus(1, 1, 0, 0);
    checkOutput("c26 reqAddr",  mem_req_addr,  32'h10C);

    // Redirect coinciding with a response and a decode pop
    applyStimulus(1, 1, 1, 32'h200);
    checkFlag  ("c27 instValid", inst_valid,   1'b0);
    checkFlag  ("c27 reqValid", mem_req_valid, 1'b0);
    applyStimulus(1, 1, 0, 0);
    checkFlag  ("c28 reqValid", mem_req_valid, 1'b1);
    checkOutput("c28 reqAddr",  mem_req_addr,  32'h200);
    checkFlag  ("c28 instValid", inst_valid,   1'b0);
    applyStimulus(1, 1, 0, 0);
    checkOutput("c29 reqAddr",  mem_req_addr,  32'h204);
    applyStimulus(1, 1, 0, 0);
    checkFlag  ("c30 instValid", inst_valid,   1'b1);
    checkOutput("c30 instPc",   inst_pc,       32'h200);

    // Memory not ready for five cycles: request held steady
    applyStimulus(0, 1, 0, 0);
    checkOutput("c31 instPc",   inst_pc,       32'h204);
    checkOutput("c31 reqAddr",  mem_req_addr,  32'h208);
    applyStimulus(0, 1, 0, 0);
    checkFlag  ("c32 reqValid", mem_req_valid, 1'b1);
    repeat (2) applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 0, 0);
    checkFlag  ("c35 reqValid", mem_req_valid, 1'b1);
    checkOutput("c35 reqAddr",  mem_req_addr,  32'h208);
    applyStimulus(1, 1, 0, 0);
    checkOutput("c36 reqAddr",  mem_req_addr,  32'h208);
    applyStimulus(1, 1, 0, 0);
    checkOutput("c37 reqAddr",  mem_req_addr,  32'h20C);
    applyStimulus(1, 1, 0, 0);
    checkOutput("c38 instPc",   inst_pc,       32'h208);
    checkOutput("c38 inst",     inst,          32'hA500_0208);

    // Fill the FIFO, then assert reset mid-stream
    applyStimulus(1, 0, 0, 0);
    checkOutput("c39 reqAddr",  mem_req_addr,  32'h210);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    checkFlag  ("c41 instValid", inst_valid,   1'b1);
    checkOutput("c41 instPc",   inst_pc,       32'h20C);
    checkFlag  ("c41 reqValid", mem_req_valid, 1'b0);
    rst = 1'b1;
    #1;
    checkFlag  ("arst reqValid",  mem_req_valid, 1'b0);
    checkFlag  ("arst instValid", inst_valid,    1'b0);
    checkOutput("arst reqAddr",   mem_req_addr,  32'h0);
    checkOutput("arst inst",      inst,          32'h0);
    checkOutput("arst instPc",    inst_pc,       32'h0);
    repeat (2) @(posedge clk);
    #1; rst = 1'b0; inst_ready = 1'b1; #3;
    checkFlag  ("r0 reqValid",  mem_req_valid, 1'b1);
    checkOutput("r0 reqAddr",   mem_req_addr,  32'h0);
    applyStimulus(1, 1, 0, 0);
    checkOutput("r1 reqAddr",   mem_req_addr,  32'h4);
    applyStimulus(1, 1, 0, 0);
    checkFlag  ("r2 instValid", inst_valid,    1'b1);
    checkOutput("r2 instPc",    inst_pc,       32'h0);
    checkOutput("r2 inst",      inst,          32'hA500_0000);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
